// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 7-segment display with minimum dwell and a blanking gap between owners.
// Optional urgent-requester-0 preemption is built only when DISP_ARB_PREEMPT_EN is defined.
module display_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned DWELL_CYCLES = 50000000,
   parameter int unsigned BLANK_CYCLES = 1000000,
   parameter logic [31:0] IDLE_VALUE   = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*32-1:0]  req_value,
   output logic [NUM_REQ-1:0]     grant,
   output logic [2:0]             owner,
   output logic [31:0]            display_value,
   output logic                   display_blank
);

   localparam int unsigned IDX_W = (NUM_REQ > 4) ? 3 : ((NUM_REQ > 2) ? 2 : 1);
   localparam int unsigned DW_W  = $clog2(DWELL_CYCLES + 1);
   localparam int unsigned GP_W  = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
   logic [2:0]           r_owner, w_owner_nxt;
   logic [31:0]          r_value, w_value_nxt;
   logic                 r_blank, w_blank_nxt;
   logic [DW_W-1:0]      r_dwell, w_dwell_nxt;
   logic [GP_W-1:0]      r_gap,   w_gap_nxt;

   logic [31:0]          w_vals [NUM_REQ];
   logic [3:0]           w_search;
   logic [NUM_REQ-1:0]   w_owner_oh;
   logic                 w_others, w_own_req, w_dwell_done, w_gap_last;
   logic [31:0]          w_own_val;
   logic                 w_preempt, w_force0, w_win_found;
   logic [2:0]           w_win;
   logic                 w_take, w_idle, w_hand;

   // First requester at or after ptr+1 (wrapping); bit 3 flags a hit
   function automatic logic [3:0] f_search(input logic [NUM_REQ-1:0] rq, input logic [2:0] ptr);
      logic       found;
      logic [2:0] idx;
      logic [2:0] cand;
      found = 1'b0;
      idx   = 3'd0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         cand = 3'((int'(ptr) + k) % int'(NUM_REQ));
         if (!found && rq[IDX_W'(cand)]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      for (int i = 0; i < int'(NUM_REQ); i++) w_vals[i] = req_value[32*i +: 32];
   end

   assign w_search     = f_search(req, r_owner);
   assign w_owner_oh   = NUM_REQ'(1) << r_owner;
   assign w_others     = |(req & ~w_owner_oh);
   assign w_own_req    = req[IDX_W'(r_owner)];
   assign w_own_val    = w_vals[IDX_W'(r_owner)];
   assign w_dwell_done = (32'(r_dwell) + 32'd1) >= DWELL_CYCLES;
   assign w_gap_last   = (32'(r_gap) + 32'd1) >= BLANK_CYCLES;

`ifdef DISP_ARB_PREEMPT_EN
   logic r_urgent;

   // Remember across the gap that the handover was a preemption
   assign w_preempt = (r_state == S_OWN) && req[0] && (r_owner != 3'd0);
   assign w_force0  = req[0] && (w_preempt || (r_urgent && (r_state == S_GAP)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                  r_urgent <= 1'b0;
      else if (w_preempt)                         r_urgent <= 1'b1;
      else if (!(r_state == S_GAP && !w_gap_last)) r_urgent <= 1'b0;
   end
`else
   assign w_preempt = 1'b0;
   assign w_force0  = 1'b0;
`endif

   assign w_win       = w_force0 ? 3'd0 : w_search[2:0];
   assign w_win_found = w_force0 | w_search[3];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_owner <= 3'(NUM_REQ - 1);
         r_value <= IDLE_VALUE;
         r_blank <= 1'b0;
         r_dwell <= '0;
         r_gap   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_owner <= w_owner_nxt;
         r_value <= w_value_nxt;
         r_blank <= w_blank_nxt;
         r_dwell <= w_dwell_nxt;
         r_gap   <= w_gap_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_owner_nxt = r_owner;
      w_value_nxt = r_value;
      w_blank_nxt = r_blank;
      w_dwell_nxt = r_dwell;
      w_gap_nxt   = r_gap;
      w_take      = 1'b0;
      w_idle      = 1'b0;
      w_hand      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (|req) w_take = 1'b1;
         end
         S_OWN: begin
            w_value_nxt = w_own_val;
            if (32'(r_dwell) < DWELL_CYCLES) w_dwell_nxt = r_dwell + DW_W'(1);
            if (!w_own_req) begin
               if (w_others) w_hand = 1'b1;
               else          w_idle = 1'b1;
            end else if (w_others && (w_dwell_done || w_preempt)) begin
               w_hand = 1'b1;
            end
         end
         S_GAP: begin
            w_gap_nxt = r_gap + GP_W'(1);
            if (w_gap_last) begin
               if (w_win_found) w_take = 1'b1;
               else             w_idle = 1'b1;
            end
         end
         default: w_idle = 1'b1;
      endcase

      // Blank the digits for the gap, keeping the old value latched
      if (w_hand) begin
         if (BLANK_CYCLES == 0) begin
            w_take = 1'b1;
         end else begin
            w_state_nxt = S_GAP;
            w_grant_nxt = '0;
            w_blank_nxt = 1'b1;
            w_gap_nxt   = '0;
            w_value_nxt = r_value;
         end
      end

      if (w_take) begin
         w_state_nxt = S_OWN;
         w_grant_nxt = NUM_REQ'(1) << w_win;
         w_owner_nxt = w_win;
         w_value_nxt = w_vals[IDX_W'(w_win)];
         w_blank_nxt = 1'b0;
         w_dwell_nxt = '0;
      end

      if (w_idle) begin
         w_state_nxt = S_IDLE;
         w_grant_nxt = '0;
         w_value_nxt = IDLE_VALUE;
         w_blank_nxt = 1'b0;
      end
   end

   assign grant         = r_grant;
   assign owner         = r_owner;
   assign display_value = r_value;
   assign display_blank = r_blank;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: reference model pushes expected outputs, a monitor pops and compares.
module tb_display_arbiter;
   localparam int          N      = 4;
   localparam int          DWELL  = 8;
   localparam int          BLANK  = 2;
   localparam logic [31:0] IDLE_V = 32'h0000_0000;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req;
   logic [127:0] req_value;
   logic [3:0]   grant;
   logic [2:0]   owner;
   logic [31:0]  display_value;
   logic         display_blank;

   always #5 clk = ~clk;

   display_arbiter #(
      .NUM_REQ(N), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK), .IDLE_VALUE(IDLE_V)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_value(req_value),
      .grant(grant), .owner(owner), .display_value(display_value), .display_blank(display_blank)
   );

   typedef struct {
      logic [3:0]  grant;
      logic [2:0]  owner;
      logic [31:0] value;
      logic        blank;
   } exp_t;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;

   // Reference model: who owns, how long, how much gap remains
   int          m_own, m_last, m_held, m_gap_left;
   bit          m_urgent, m_blank;
   logic [31:0] m_value;

   // Inputs the DUT saw at the most recent edge, and values queued for the next tick
   bit          a_rst;
   logic [3:0]  a_req;
   logic [31:0] a_vals [N];
   logic [31:0] n_vals [N];

   function automatic int m_pick(input logic [3:0] rq);
`ifdef DISP_ARB_PREEMPT_EN
      if (m_urgent && rq[0]) return 0;
`endif
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_last + k) % N;
         if (rq[c]) return c;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_own = -1; m_last = N - 1; m_held = 0; m_gap_left = 0;
      m_urgent = 0; m_blank = 0; m_value = IDLE_V;
   endtask

   task automatic m_take(input int w);
      m_own = w; m_last = w; m_held = 0; m_value = a_vals[w];
      m_blank = 0; m_gap_left = 0; m_urgent = 0;
   endtask

   task automatic m_go_idle();
      m_own = -1; m_value = IDLE_V; m_blank = 0; m_urgent = 0; m_gap_left = 0;
   endtask

   task automatic m_handover(input bit pre);
      m_urgent = pre;
      if (BLANK == 0) m_take(m_pick(a_req));
      else begin
         m_own = -1; m_gap_left = BLANK; m_blank = 1;
      end
   endtask

   task automatic m_step();
      int w;
      bit others, pre;
      if (m_gap_left > 0) begin
         if (m_gap_left == 1) begin
            w = m_pick(a_req);
            m_gap_left = 0;
            if (w >= 0) m_take(w);
            else        m_go_idle();
         end else begin
            m_gap_left--;
         end
      end else if (m_own < 0) begin
         if (a_req != 4'b0) m_take(m_pick(a_req));
      end else begin
         others = (a_req & ~(4'b0001 << m_own)) != 4'b0;
         pre = 0;
`ifdef DISP_ARB_PREEMPT_EN
         pre = (m_own != 0) && a_req[0];
`endif
         if (!a_req[m_own]) begin
            if (others) m_handover(pre);
            else        m_go_idle();
         end else if (others && ((m_held + 1 >= DWELL) || pre)) begin
            m_handover(pre);
         end else begin
            m_held++;
            m_value = a_vals[m_own];
         end
      end
   endtask

   // One clock: advance the model over the edge, apply new inputs, queue what the DUT should show
   task automatic tick(input bit rst, input logic [3:0] rq);
      exp_t e;
      @(posedge clk);
      #1;
      if (!a_rst) m_step();
      a_rst = rst;
      a_req = rq;
      for (int i = 0; i < N; i++) a_vals[i] = n_vals[i];
      reset     = rst;
      req       = rq;
      req_value = {a_vals[3], a_vals[2], a_vals[1], a_vals[0]};
      if (rst) m_reset();
      e.grant = (m_own >= 0) ? 4'(4'b0001 << m_own) : 4'b0000;
      e.owner = 3'(m_last);
      e.value = m_value;
      e.blank = m_blank;
      sb_q.push_back(e);
   endtask

   task automatic set_vals(input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3);
      n_vals[0] = v0; n_vals[1] = v1; n_vals[2] = v2; n_vals[3] = v3;
   endtask

   task automatic ticks(input int n, input logic [3:0] rq);
      for (int i = 0; i < n; i++) tick(1'b0, rq);
   endtask

   task automatic do_reset();
      tick(1'b1, 4'b0000);
      tick(1'b1, 4'b0000);
   endtask

   // Monitor: outputs are presented every cycle, checked mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_total++;
            if (grant !== e.grant || owner !== e.owner || display_value !== e.value ||
                display_blank !== e.blank) begin
               n_bad++;
               $display("FAIL outputs cyc=%0d grant/owner/value/blank got %b/%0d/%h/%b want %b/%0d/%h/%b",
                        cyc, grant, owner, display_value, display_blank,
                        e.grant, e.owner, e.value, e.blank);
            end
            n_total++;
            if (!$onehot0(grant)) begin
               n_bad++;
               $display("FAIL onehot cyc=%0d grant got %b want at most one bit", cyc, grant);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; req = '0; req_value = '0;
      a_rst = 1'b1; a_req = '0;
      for (int i = 0; i < N; i++) begin a_vals[i] = '0; n_vals[i] = '0; end
      m_reset();

      // Single requester holds the display indefinitely
      do_reset();
      set_vals(32'h1111_0000, 32'h2222_0001, 32'h0000_1234, 32'h4444_0003);
      ticks(22, 4'b0100);

      // Two continuous requesters alternate with dwell and gap
      do_reset();
      set_vals(32'hA0A0_0000, 32'hB1B1_0001, 32'hC2C2_0002, 32'hD3D3_0003);
      ticks(40, 4'b1010);

      // Owner drops with another pending, then drops alone
      do_reset();
      ticks(2, 4'b0010);
      ticks(1, 4'b1010);
      ticks(12, 4'b1000);
      do_reset();
      ticks(4, 4'b0010);
      ticks(4, 4'b0000);

      // Passthrough of a changing value
      do_reset();
      set_vals(32'h0, 32'h0, 32'h0000_1234, 32'h0);
      ticks(4, 4'b0100);
      set_vals(32'h0, 32'h0, 32'h0000_ABCD, 32'h0);
      ticks(4, 4'b0100);

      // Requester 0 arrives while requester 3 owns
      do_reset();
      set_vals(32'h0000_0A00, 32'h0, 32'h0, 32'h0000_0A03);
      ticks(3, 4'b1000);
      ticks(14, 4'b1001);

      // Reset landing inside a gap, then restart
      do_reset();
      set_vals(32'h5, 32'h0000_0B01, 32'h7, 32'h0000_0B03);
      ticks(10, 4'b1010);
      tick(1'b1, 4'b1010);
      ticks(30, 4'b1010);

      // Randomised requests, values and occasional reset
      begin
         logic [3:0] rq;
         rq = 4'b0000;
         for (int c = 0; c < 900; c++) begin
            for (int i = 0; i < N; i++) n_vals[i] = $urandom;
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            tick($urandom_range(0, 149) == 0, rq);
         end
      end

      tick(1'b0, 4'b0000);
      @(negedge clk);
      #1;
      n_total++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain queue left=%0d want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
